rst_seq_ctrl: RTL and testbench
===============================

# rst_seq_ctrl

Reset sequencer that generates ordered reset releases for several downstream blocks in one clock domain. It asserts all reset outputs asynchronously and holds them for a fixed time. It then de-asserts them one by one at fixed intervals. It restarts the sequence on a software reset request or on loss of PLL lock. It sits between the board/PLL reset sources and the per-block reset inputs of the clk domain.

## Interface
- NUM_DOMAINS, 4, number of reset outputs, legal 1..16
- HOLD_CYCLES, 16, cycles all outputs stay asserted after the sequence (re)starts, ≥1
- STEP_CYCLES, 8, cycles between successive domain releases, ≥1
- O_RESET_LEVEL, 1'b0, asserted level of rst_o (0 = active-low)

- clk  in  1  sequencer clock
- rst_i  in  1  reset; asynchronous, active-low
- pll_lock_i  in  1  PLL lock, already synchronous to clk; 1 = locked
- sw_rst_req_i  in  1  synchronous software reset request, sampled every edge
- rst_o  out  NUM_DOMAINS  per-domain reset; bit 0 is released first
- done_o  out  1  1 = all domains released
- rel_cnt_o  out  $clog2(NUM_DOMAINS+1)  number of domains currently released

## Operation
- rst_i low: asynchronously rst_o = all O_RESET_LEVEL, done_o = 0, rel_cnt_o = 0, state HOLD, counter 0.
- rst_i release passes through an internal 2-flop synchronizer. The sequencer is held in reset until the synchronized release, which occurs after edge 2.
- States:
  - HOLD: counter increments on every edge where pll_lock_i = 1. On the HOLD_CYCLES-th counting edge: rst_o[0] released, rel_cnt_o = 1, counter cleared. If NUM_DOMAINS = 1, next state is DONE; otherwise next state is RELEASE.
  - RELEASE: counter increments every edge. When counter = STEP_CYCLES-1, the next domain is released, rel_cnt_o increments and the counter clears. The edge that releases domain NUM_DOMAINS-1 moves the FSM to DONE.
  - DONE: done_o = 1 starting the edge after DONE is entered. The FSM stays in DONE.
- Restart condition: sw_rst_req_i = 1, or pll_lock_i = 0, sampled on an edge, in any state. On that same edge:
  - all rst_o are asserted
  - done_o = 0
  - rel_cnt_o = 0
  - counter = 0
  - state = HOLD
- Restart has priority over a release scheduled on the same edge. The release does not happen.
- A request during HOLD restarts the hold count.
- While pll_lock_i = 0, the sequencer stays in HOLD with counter 0.
- Released domains never re-assert except through a restart or rst_i.
- rst_o bits are driven straight from flops; no combinational logic follows them.

## Timing
- Edges are counted from the first clk edge at which rst_i is high (edge 1). pll_lock_i is 1 and there are no requests.
- Domain k release edge: 2 + HOLD_CYCLES + k·STEP_CYCLES.
- done_o rises one edge after the last release.
- After a restart sampled at edge N, domain k is released at edge N + HOLD_CYCLES + k·STEP_CYCLES. There is no synchronizer delay in this case.
- Width rules:
  - The counter is $clog2(max(HOLD_CYCLES, STEP_CYCLES)+1) bits wide and never wraps; it is cleared explicitly.
  - rel_cnt_o saturates at NUM_DOMAINS.
- Assertion latency:
  - rst_i: asynchronous, zero cycles.
  - Request or lock loss: one edge.

## Structure
- Package rst_seq_pkg holds:
  - state enum rst_seq_state_e {ST_HOLD, ST_RELEASE, ST_DONE}
  - function cnt_width(HOLD, STEP) giving the counter width
- Sub-module: the existing reset_sync synchronizer, instantiated with I_RESET_LEVEL = 0 and O_RESET_LEVEL = 0. Its output is the async reset for all sequencer flops.
- Parameter legality is checked at elaboration with $error.

## Test plan
- Power-up (NUM_DOMAINS=4, HOLD=16, STEP=8), rst_i rises before edge 1 → rst_o bits 0..3 release at edges 18, 26, 34, 42; done_o = 1 at edge 43; rel_cnt_o steps 1, 2, 3, 4.
- sw_rst_req_i one-cycle pulse at edge 60 (in DONE) → rst_o = 4'b0000, done_o = 0, rel_cnt_o = 0 at edge 60; releases at 76, 84, 92, 100.
- pll_lock_i low over edges 30–39 (mid-sequence) → all asserted at edge 30, held; counting resumes at edge 40; bit 0 released at edge 55 (16th counting edge).
- sw_rst_req_i at edge 26, the scheduled bit-1 release edge → bit 1 stays asserted, bit 0 re-asserted, restart from edge 26.
- rst_i pulsed low between edges 30 and 31 → rst_o asserted immediately without waiting for a clock edge; the sequence replays with the power-up timing relative to the new release.
- NUM_DOMAINS=1, HOLD=1, STEP=1 → rst_o released at edge 3, done_o at edge 4.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  // Largest number of reset outputs one sequencer may drive.
  localparam int MAX_DOMAINS = 16;

  // Sequencer phases: all asserted, staggered release, all released.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } rst_seq_state_e;

  // Width of the hold/step counter.
  // The counter only ever reaches max(hold, step) - 1 before it is cleared,
  // so max + 1 values always fit.
  function automatic int cnt_width(input int hold, input int step);
    int m;
    m = (hold > step) ? hold : step;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously, releases after STAGES clock
// edges. The output comes straight from the last flop.
module reset_sync #(
  parameter logic I_RESET_LEVEL = 1'b0,
  parameter logic O_RESET_LEVEL = 1'b0,
  parameter int   STAGES        = 2
) (
  input  logic clk,
  input  logic rst_i,
  output logic rst_o
);

  // Internal active-low view of the incoming reset, whatever its polarity.
  logic arst_n;
  assign arst_n = (rst_i != I_RESET_LEVEL);

  logic [STAGES-1:0] sync_q;

  // Shift the de-asserted level in. A reset forces every stage back to the
  // asserted output level without waiting for a clock.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= {STAGES{O_RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], ~O_RESET_LEVEL};
    end
  end

  assign rst_o = sync_q[STAGES-1];

  if (STAGES < 2) begin : g_bad_stages
    $error("reset_sync: STAGES must be at least 2");
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds every downstream reset asserted for HOLD_CYCLES
// locked clocks, then releases domain 0, 1, ... one every STEP_CYCLES.
// A software request or a loss of PLL lock restarts the whole sequence
// on the edge that samples it; rst_i restarts it asynchronously.
//
// Request semantics: sw_rst_req_i is a level, sampled on every clk edge.
// Each edge that sees it high is a restart; there is no acknowledge.
// pll_lock_i low acts as a request held for as long as it stays low.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int   NUM_DOMAINS   = 4,
  parameter int   HOLD_CYCLES   = 16,
  parameter int   STEP_CYCLES   = 8,
  parameter logic O_RESET_LEVEL = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst_i,
  input  logic                               pll_lock_i,
  input  logic                               sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0]             rst_o,
  output logic                               done_o,
  output logic [$clog2(NUM_DOMAINS+1)-1:0]   rel_cnt_o,
  output rst_seq_state_e                     dbg_state_o
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam int REL_W = $clog2(NUM_DOMAINS + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [REL_W-1:0] REL_LAST  = REL_W'(NUM_DOMAINS - 1);
  localparam logic [REL_W-1:0] REL_MAX   = REL_W'(NUM_DOMAINS);

  // Parameter legality, caught at elaboration.
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > MAX_DOMAINS) begin : g_bad_domains
    $error("rst_seq_ctrl: NUM_DOMAINS must be in 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_seq_ctrl: HOLD_CYCLES must be at least 1");
  end
  if (STEP_CYCLES < 1) begin : g_bad_step
    $error("rst_seq_ctrl: STEP_CYCLES must be at least 1");
  end

  // Synchronized, active-low reset for every sequencer flop. Assertion is
  // immediate; release lands two edges after rst_i rises.
  logic seq_rst_n;

  reset_sync #(
    .I_RESET_LEVEL (1'b0),
    .O_RESET_LEVEL (1'b0),
    .STAGES        (2)
  ) u_reset_sync (
    .clk   (clk),
    .rst_i (rst_i),
    .rst_o (seq_rst_n)
  );

  rst_seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [REL_W-1:0]       rel_q,   rel_d;
  logic [NUM_DOMAINS-1:0] rst_q,   rst_d;
  logic                   done_q,  done_d;
  logic                   restart;

  // Lock loss behaves exactly like a software request.
  assign restart = sw_rst_req_i | ~pll_lock_i;

  // State register. Every output is taken from here, so the downstream
  // resets see clean flop outputs with no logic after them.
  always_ff @(posedge clk or negedge seq_rst_n) begin
    if (!seq_rst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      rel_q   <= '0;
      rst_q   <= {NUM_DOMAINS{O_RESET_LEVEL}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Restart is checked first so it wins over a release
  // that would otherwise fall on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    rst_d   = rst_q;
    done_d  = (state_q == ST_DONE);

    if (restart) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      rel_d   = '0;
      rst_d   = {NUM_DOMAINS{O_RESET_LEVEL}};
      done_d  = 1'b0;
    end else begin
      case (state_q)
        // Lock is known to be high here (otherwise restart fired), so
        // every edge in this branch is a counting edge.
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_d[0] = ~O_RESET_LEVEL;
            rel_d    = REL_W'(1);
            cnt_d    = '0;
            state_d  = (NUM_DOMAINS == 1) ? ST_DONE : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        // rel_q is both the count of released domains and the index of
        // the next domain to release.
        ST_RELEASE: begin
          if (cnt_q == STEP_LAST) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (rel_q == REL_W'(i)) begin
                rst_d[i] = ~O_RESET_LEVEL;
              end
            end
            if (rel_q != REL_MAX) begin
              rel_d = rel_q + 1'b1;
            end
            cnt_d = '0;
            if (rel_q == REL_LAST) begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        // Terminal until the next restart.
        ST_DONE: begin
          cnt_d = '0;
        end

        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          rel_d   = '0;
          rst_d   = {NUM_DOMAINS{O_RESET_LEVEL}};
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign rst_o       = rst_q;
  assign done_o      = done_q;
  assign rel_cnt_o   = rel_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: a 4-domain instance with default timing
// and a 1-domain, HOLD=1, STEP=1 instance sharing the clock and rst_i.
// Edge numbers restart at 1 on the first posedge after rst_i rises.
module tb_rst_seq_ctrl;
  import rst_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic           pll_lock = 1'b1;
  logic           sw_req   = 1'b0;
  logic [3:0]     rst_o;
  logic           done;
  logic [2:0]     rel_cnt;
  rst_seq_state_e state;

  logic           pll_lock1 = 1'b1;
  logic           sw_req1   = 1'b0;
  logic [0:0]     rst1_o;
  logic           done1;
  logic [0:0]     rel1;
  rst_seq_state_e state1;

  rst_seq_ctrl #(
    .NUM_DOMAINS(4), .HOLD_CYCLES(16), .STEP_CYCLES(8), .O_RESET_LEVEL(1'b0)
  ) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .pll_lock_i   (pll_lock),
    .sw_rst_req_i (sw_req),
    .rst_o        (rst_o),
    .done_o       (done),
    .rel_cnt_o    (rel_cnt),
    .dbg_state_o  (state)
  );

  rst_seq_ctrl #(
    .NUM_DOMAINS(1), .HOLD_CYCLES(1), .STEP_CYCLES(1), .O_RESET_LEVEL(1'b0)
  ) dut1 (
    .clk          (clk),
    .rst_i        (rst_i),
    .pll_lock_i   (pll_lock1),
    .sw_rst_req_i (sw_req1),
    .rst_o        (rst1_o),
    .done_o       (done1),
    .rel_cnt_o    (rel1),
    .dbg_state_o  (state1)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int edge_n       = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  // Main instance outputs in one call.
  task automatic chk_out(input string tag, input logic [3:0] e_rst,
                         input logic e_done, input logic [2:0] e_rel);
    chk({tag, ".rst_o"},   32'(rst_o),   32'(e_rst));
    chk({tag, ".done_o"},  32'(done),    32'(e_done));
    chk({tag, ".rel_cnt"}, 32'(rel_cnt), 32'(e_rel));
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the target edge; outputs are sampled #1 later.
  task automatic run_to(input int target);
    if (target < edge_n) begin
      chk("run_to_order", 32'(edge_n), 32'(target));
    end
    while (edge_n < target) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  // Drop rst_i, check the asserted state, then raise it half a cycle
  // before the new edge 1.
  task automatic power_up(input string tag);
    pll_lock = 1'b1;
    sw_req   = 1'b0;
    rst_i    = 1'b0;
    #1;
    chk_out({tag, ".in_reset"}, 4'b0000, 1'b0, 3'd0);
    chk({tag, ".in_reset.state"}, 32'(state), 32'(ST_HOLD));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i  = 1'b1;
    edge_n = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    #1;

    // Power-up ordering, plus the 1-domain instance on the same reset.
    power_up("pwr");
    run_to(2);
    chk("one.e2.rst", 32'(rst1_o), 32'd0);
    run_to(3);
    chk("one.e3.rst", 32'(rst1_o), 32'd1);
    chk("one.e3.done", 32'(done1), 32'd0);
    chk("one.e3.rel", 32'(rel1), 32'd1);
    run_to(4);
    chk("one.e4.done", 32'(done1), 32'd1);
    chk("one.e4.state", 32'(state1), 32'(ST_DONE));
    run_to(17); chk_out("pwr.e17", 4'b0000, 1'b0, 3'd0);
    run_to(18); chk_out("pwr.e18", 4'b0001, 1'b0, 3'd1);
    chk("pwr.e18.state", 32'(state), 32'(ST_RELEASE));
    run_to(25); chk_out("pwr.e25", 4'b0001, 1'b0, 3'd1);
    run_to(26); chk_out("pwr.e26", 4'b0011, 1'b0, 3'd2);
    run_to(34); chk_out("pwr.e34", 4'b0111, 1'b0, 3'd3);
    run_to(41); chk_out("pwr.e41", 4'b0111, 1'b0, 3'd3);
    run_to(42); chk_out("pwr.e42", 4'b1111, 1'b0, 3'd4);
    run_to(43); chk_out("pwr.e43", 4'b1111, 1'b1, 3'd4);
    chk("pwr.e43.state", 32'(state), 32'(ST_DONE));

    // One-cycle software request sampled at edge 60, while in DONE.
    run_to(59);
    chk_out("sw.e59", 4'b1111, 1'b1, 3'd4);
    sw_req = 1'b1;
    run_to(60);
    sw_req = 1'b0;
    chk_out("sw.e60", 4'b0000, 1'b0, 3'd0);
    chk("sw.e60.state", 32'(state), 32'(ST_HOLD));
    run_to(75);  chk_out("sw.e75",  4'b0000, 1'b0, 3'd0);
    run_to(76);  chk_out("sw.e76",  4'b0001, 1'b0, 3'd1);
    run_to(84);  chk_out("sw.e84",  4'b0011, 1'b0, 3'd2);
    run_to(92);  chk_out("sw.e92",  4'b0111, 1'b0, 3'd3);
    run_to(100); chk_out("sw.e100", 4'b1111, 1'b0, 3'd4);
    run_to(101); chk_out("sw.e101", 4'b1111, 1'b1, 3'd4);

    // PLL lock low over edges 30..39, mid-sequence.
    power_up("lock");
    run_to(29);
    chk_out("lock.e29", 4'b0011, 1'b0, 3'd2);
    pll_lock = 1'b0;
    run_to(30); chk_out("lock.e30", 4'b0000, 1'b0, 3'd0);
    run_to(39); chk_out("lock.e39", 4'b0000, 1'b0, 3'd0);
    chk("lock.e39.state", 32'(state), 32'(ST_HOLD));
    pll_lock = 1'b1;
    run_to(54); chk_out("lock.e54", 4'b0000, 1'b0, 3'd0);
    run_to(55); chk_out("lock.e55", 4'b0001, 1'b0, 3'd1);
    run_to(63); chk_out("lock.e63", 4'b0011, 1'b0, 3'd2);

    // Request on the edge that would release bit 1: restart wins.
    power_up("race");
    run_to(25);
    chk_out("race.e25", 4'b0001, 1'b0, 3'd1);
    sw_req = 1'b1;
    run_to(26);
    sw_req = 1'b0;
    chk_out("race.e26", 4'b0000, 1'b0, 3'd0);
    run_to(41); chk_out("race.e41", 4'b0000, 1'b0, 3'd0);
    run_to(42); chk_out("race.e42", 4'b0001, 1'b0, 3'd1);
    run_to(50); chk_out("race.e50", 4'b0011, 1'b0, 3'd2);

    // rst_i pulsed low between edges 30 and 31: assertion needs no clock.
    power_up("arst");
    run_to(30);
    chk_out("arst.e30", 4'b0011, 1'b0, 3'd2);
    rst_i = 1'b0;
    #1;
    chk_out("arst.async", 4'b0000, 1'b0, 3'd0);
    chk("arst.async.state", 32'(state), 32'(ST_HOLD));
    chk("arst.async.one", 32'(rst1_o), 32'd0);
    @(negedge clk);
    rst_i  = 1'b1;
    edge_n = 0;
    run_to(3);  chk("arst.one.e3", 32'(rst1_o), 32'd1);
    run_to(17); chk_out("arst.e17", 4'b0000, 1'b0, 3'd0);
    run_to(18); chk_out("arst.e18", 4'b0001, 1'b0, 3'd1);
    run_to(42); chk_out("arst.e42", 4'b1111, 1'b0, 3'd4);
    run_to(43); chk_out("arst.e43", 4'b1111, 1'b1, 3'd4);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
